// File: rtl/combo_str.sv
// combo_str: decorative LED pattern generator for 27 board LEDs plus a
// two-digit 7-segment readout of the current pattern position.
//
// Ports
//   clk_50      system clock, everything on posedge
//   rst         synchronous active-high reset, overrides every other input
//   en          run enable; low freezes the prescaler and the pattern
//   sw_1..sw_4  mode select switches, sw_1 highest priority
//   led         LED drive, 1 = on, bit 0 = rightmost
//   hex0        units digit, active-low segments {g,f,e,d,c,b,a}
//   hex1        tens digit, same encoding
//
// Build option
//   COMBO_STR_HEX_EN  defined   : hex0/hex1 show pos in decimal
//                     undefined : hex0/hex1 blank (7'h7F), no digit logic
//
// Mode table (mode_r)
//   mode      | meaning
//   MODE_OFF  | all LEDs off, pos held at 0
//   MODE_CHASE| single LED walking up, wraps 26 -> 0
//   MODE_BAR  | bar fill of LEDs 0..pos, wraps 26 -> 0
//   MODE_BLINK| alternating even/odd LEDs, pos parity selects the set
//   MODE_PONG | single LED bouncing 0..26..0, end LEDs not repeated
module combo_str #(
  parameter int CLK_DIV = 1,
  parameter int N_LED   = 27
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             en,
  input  logic             sw_1,
  input  logic             sw_2,
  input  logic             sw_3,
  input  logic             sw_4,
  output logic [N_LED-1:0] led,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1
);

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_CHASE = 3'd1;
  localparam logic [2:0] MODE_BAR   = 3'd2;
  localparam logic [2:0] MODE_BLINK = 3'd3;
  localparam logic [2:0] MODE_PONG  = 3'd4;

  localparam int         CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [4:0] POS_LAST = 5'(N_LED - 1);

  logic [2:0]    mode_r;
  logic [2:0]    mode_dec;
  logic [4:0]    pos;
  logic          dir;     // 0 = moving up, 1 = moving down
  logic [CW-1:0] cnt;
  logic          tick;

  always_comb begin
    mode_dec = MODE_OFF;
    if (sw_1)      mode_dec = MODE_CHASE;
    else if (sw_2) mode_dec = MODE_BAR;
    else if (sw_3) mode_dec = MODE_BLINK;
    else if (sw_4) mode_dec = MODE_PONG;
  end

  assign tick = en && (cnt == CNT_LAST);

  // A mode change restarts the pattern and swallows any tick on that clock.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      mode_r <= MODE_OFF;
      pos    <= '0;
      dir    <= 1'b0;
      cnt    <= '0;
    end else if (mode_dec != mode_r) begin
      mode_r <= mode_dec;
      pos    <= '0;
      dir    <= 1'b0;
      cnt    <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
        case (mode_r)
          MODE_CHASE, MODE_BAR, MODE_BLINK: begin
            pos <= (pos == POS_LAST) ? 5'd0 : pos + 5'd1;
          end
          MODE_PONG: begin
            // Turn around at the ends by moving straight to the neighbour,
            // so the end LEDs are lit for one step only.
            if (!dir) begin
              if (pos == POS_LAST) begin
                dir <= 1'b1;
                pos <= POS_LAST - 5'd1;
              end else begin
                pos <= pos + 5'd1;
              end
            end else begin
              if (pos == 5'd0) begin
                dir <= 1'b0;
                pos <= 5'd1;
              end else begin
                pos <= pos - 5'd1;
              end
            end
          end
          default: pos <= '0;
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (mode_r)
        MODE_CHASE, MODE_PONG: led[i] = (i == int'(pos));
        MODE_BAR:              led[i] = (i <= int'(pos));
        MODE_BLINK:            led[i] = ((i % 2) == 1) == pos[0];
        default:               led[i] = 1'b0;
      endcase
    end
  end

`ifdef COMBO_STR_HEX_EN
  function automatic logic [6:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    seg_font = 7'h40;
      4'd1:    seg_font = 7'h79;
      4'd2:    seg_font = 7'h24;
      4'd3:    seg_font = 7'h30;
      4'd4:    seg_font = 7'h19;
      4'd5:    seg_font = 7'h12;
      4'd6:    seg_font = 7'h02;
      4'd7:    seg_font = 7'h78;
      4'd8:    seg_font = 7'h00;
      4'd9:    seg_font = 7'h10;
      default: seg_font = 7'h7F;
    endcase
  endfunction

  logic [3:0] tens;
  logic [4:0] units;

  // pos never exceeds 26, so two compares replace a divider.
  always_comb begin
    tens  = 4'd0;
    units = pos;
    if (pos >= 5'd20) begin
      tens  = 4'd2;
      units = pos - 5'd20;
    end else if (pos >= 5'd10) begin
      tens  = 4'd1;
      units = pos - 5'd10;
    end
  end

  assign hex0 = seg_font(units[3:0]);
  assign hex1 = seg_font(tens);
`else
  assign hex0 = 7'h7F;
  assign hex1 = 7'h7F;
`endif

endmodule

// File: tb/tb_combo_str.sv
// Bench for combo_str: two instances (CLK_DIV=1 and CLK_DIV=4) share the
// same stimulus and are compared every clock against a step-count model.
module tb_combo_str;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sw_1 = 1'b0, sw_2 = 1'b0, sw_3 = 1'b0, sw_4 = 1'b0;
  logic [26:0] led_a, led_b;
  logic [6:0]  hex0_a, hex1_a, hex0_b, hex1_b;

  int checks = 0;
  int errors = 0;

  always #5 clk_50 = ~clk_50;

  combo_str #(.CLK_DIV(1), .N_LED(27)) u_div1 (
    .clk_50(clk_50), .rst(rst), .en(en),
    .sw_1(sw_1), .sw_2(sw_2), .sw_3(sw_3), .sw_4(sw_4),
    .led(led_a), .hex0(hex0_a), .hex1(hex1_a)
  );

  combo_str #(.CLK_DIV(4), .N_LED(27)) u_div4 (
    .clk_50(clk_50), .rst(rst), .en(en),
    .sw_1(sw_1), .sw_2(sw_2), .sw_3(sw_3), .sw_4(sw_4),
    .led(led_b), .hex0(hex0_b), .hex1(hex1_b)
  );

  // Model: mode, number of steps taken since the mode was loaded, prescaler.
  int divv [2] = '{1, 4};
  int m_mode [2];
  int m_k [2];
  int m_cnt [2];

  function automatic int sel_mode();
    if (sw_1) return 1;
    if (sw_2) return 2;
    if (sw_3) return 3;
    if (sw_4) return 4;
    return 0;
  endfunction

  function automatic int exp_pos(int mode, int k);
    int p;
    if (mode == 0) return 0;
    if (mode == 4) begin
      p = k % 52;
      return (p <= 26) ? p : 52 - p;
    end
    return k % 27;
  endfunction

  function automatic logic [26:0] exp_led(int mode, int p);
    logic [26:0] v;
    v = '0;
    case (mode)
      1, 4: v = 27'd1 << p;
      2:    v = (27'd1 << p) | ((27'd1 << p) - 27'd1);
      3:    v = (p % 2 == 0) ? 27'h5555555 : 27'h2AAAAAA;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [6:0] font(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(int p, bit tens_digit);
`ifdef COMBO_STR_HEX_EN
    return tens_digit ? font(p / 10) : font(p % 10);
`else
    return 7'h7F;
`endif
  endfunction

  task automatic model_update();
    int d;
    d = sel_mode();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_k[i] = 0; m_cnt[i] = 0;
      end else if (d != m_mode[i]) begin
        m_mode[i] = d; m_k[i] = 0; m_cnt[i] = 0;
      end else if (en) begin
        if (m_cnt[i] == divv[i] - 1) begin
          m_cnt[i] = 0;
          if (m_mode[i] != 0) m_k[i] = m_k[i] + 1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    int p;
    p = exp_pos(m_mode[0], m_k[0]);
    chk("div1_led",  32'(led_a),  32'(exp_led(m_mode[0], p)));
    chk("div1_hex0", 32'(hex0_a), 32'(exp_hex(p, 1'b0)));
    chk("div1_hex1", 32'(hex1_a), 32'(exp_hex(p, 1'b1)));
    p = exp_pos(m_mode[1], m_k[1]);
    chk("div4_led",  32'(led_b),  32'(exp_led(m_mode[1], p)));
    chk("div4_hex0", 32'(hex0_b), 32'(exp_hex(p, 1'b0)));
    chk("div4_hex1", 32'(hex1_b), 32'(exp_hex(p, 1'b1)));
  endtask

  task automatic step(int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk_50);
      model_update();
      #1;
      compare_all();
    end
  endtask

  task automatic set_sw(logic [3:0] s);
    {sw_1, sw_2, sw_3, sw_4} = s;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_k[i] = 0; m_cnt[i] = 0;
    end

    // Reset held with sw_4 up and en low.
    rst = 1'b1; en = 1'b0; set_sw(4'b0001);
    step(1);
    chk("reset_led_zero", 32'(led_a), 32'd0);
    step(2);

    // Release reset: one clock to load ping-pong, then hold with en low.
    rst = 1'b0;
    step(3);

    // Ping-pong runs past two full bounce periods on the fast instance.
    en = 1'b1;
    step(120);

    // Chase, bar fill, blink, then sw_1 overriding sw_3 mid-run.
    set_sw(4'b1000); step(60);
    set_sw(4'b0100); step(60);
    set_sw(4'b0010); step(12);
    set_sw(4'b1010); step(5);
    set_sw(4'b0000); step(3);

    // Prescaler pause/resume mid-count in chase mode.
    set_sw(4'b1000); step(6);
    en = 1'b0; step(5);
    en = 1'b1; step(10);

    // Reset mid-run aborts the pattern regardless of en and switches.
    rst = 1'b1; step(1);
    chk("midrun_reset_led", 32'(led_b), 32'd0);
    rst = 1'b0; step(8);

    // Random switches, enable and occasional reset.
    for (int r = 0; r < 500; r++) begin
      if ($urandom_range(0, 15) == 0) set_sw(4'($urandom_range(0, 15)));
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
